// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver; start, DataBits data (MSB first), optional even parity, StopBits stop bits.
// Latency: data_out_valid rises 1 clk after the mid-point of the last stop bit (+2 clk synchroniser delay).
// Backpressure: none; the consumer must capture data_out on the one-cycle data_out_valid strobe.
// Optional build macro UART_RX_MAJORITY_EN: 2-of-3 majority sampling around mid-bit, committed one clock later.

module uart_rx #(
  parameter int ClockDivider = 8,
  parameter int DataBits     = 8,
  parameter int StopBits     = 1,
  parameter int ParityBits   = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_bit,
  output logic [DataBits-1:0] data_out,
  output logic                data_out_valid,
  output logic                parity_error,
  output logic                frame_error,
  output logic                busy
);

  localparam int CW = $clog2(ClockDivider);
  localparam int BW = $clog2(DataBits + 1);

`ifdef UART_RX_MAJORITY_EN
  // Majority voting commits each bit at mid+1, so every decision moves one clock later.
  localparam int Lag = 1;
`else
  localparam int Lag = 0;
`endif

  // Start bit is judged half a bit after the falling edge; every later bit one full period after that.
  localparam logic [CW-1:0] StartPt = CW'(ClockDivider / 2 - 1 + Lag);
  localparam logic [CW-1:0] BitPt   = CW'(ClockDivider - 1);
  localparam logic [BW-1:0] LastData = BW'(DataBits - 1);
  localparam logic [BW-1:0] LastStop = BW'(StopBits - 1);

  // Reject parameter sets the datapath cannot support.
  generate
    if (ClockDivider < 4) begin : g_bad_div
      $error("uart_rx: ClockDivider must be >= 4");
    end
    if (DataBits < 5 || DataBits > 9) begin : g_bad_data
      $error("uart_rx: DataBits must be in [5,9]");
    end
    if (StopBits != 1 && StopBits != 2) begin : g_bad_stop
      $error("uart_rx: StopBits must be 1 or 2");
    end
    if (ParityBits != 0 && ParityBits != 1) begin : g_bad_par
      $error("uart_rx: ParityBits must be 0 or 1");
    end
  endgenerate

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } state_t;

  state_t              state;
  state_t              state_nxt;

  logic                rx_meta;
  logic                rx;
  logic [CW-1:0]       cnt;
  logic [BW-1:0]       bit_cnt;
  logic [DataBits-1:0] shift_reg;
  logic                par_err;
  logic                frame_flag;

  logic [CW-1:0]       commit_pt;
  logic                tick;
  logic                bit_val;
  logic                last_data;
  logic                last_stop;
  logic                shift_en;
  logic                par_en;
  logic                stop_en;
  logic                frame_done;

  // Two-flop synchroniser; resets to the idle-high line level so reset never looks like a start bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx      <= 1'b1;
    end else begin
      rx_meta <= in_bit;
      rx      <= rx_meta;
    end
  end

  // Decision point within the current bit and the bit-count boundaries.
  always_comb begin
    commit_pt = (state == START) ? StartPt : BitPt;
    tick      = (cnt == commit_pt);
    last_data = (bit_cnt == LastData);
    last_stop = (bit_cnt == LastStop);
  end

`ifdef UART_RX_MAJORITY_EN
  logic maj_a;
  logic maj_b;

  // Capture the two samples preceding the commit point (mid-1 and mid).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      maj_a <= 1'b1;
      maj_b <= 1'b1;
    end else begin
      if (cnt == commit_pt - CW'(2)) maj_a <= rx;
      if (cnt == commit_pt - CW'(1)) maj_b <= rx;
    end
  end

  // 2-of-3 vote using the live sample at mid+1 as the third vote.
  always_comb begin
    bit_val = (maj_a & maj_b) | (maj_a & rx) | (maj_b & rx);
  end
`else
  // Single sample at mid-bit.
  always_comb begin
    bit_val = rx;
  end
`endif

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (!rx) state_nxt = START;
      START:   if (tick) state_nxt = bit_val ? IDLE : DATA;
      DATA:    if (tick && last_data) state_nxt = (ParityBits == 1) ? PARITY : STOP;
      PARITY:  if (tick) state_nxt = STOP;
      STOP:    if (tick && last_stop) state_nxt = (frame_flag || !bit_val) ? BREAK : IDLE;
      BREAK:   if (rx) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs: busy flag and per-state sample enables.
  always_comb begin
    busy       = (state != IDLE);
    shift_en   = (state == DATA)   && tick;
    par_en     = (state == PARITY) && tick;
    stop_en    = (state == STOP)   && tick;
    frame_done = stop_en && last_stop;
  end

  // Clock-divider counter: held at 0 while waiting, wraps explicitly at each decision point.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (state == IDLE || state == BREAK || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  // Bit counter: counts data samples, then is reused to count stop samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt <= '0;
    end else if (state == IDLE) begin
      bit_cnt <= '0;
    end else if (shift_en) begin
      bit_cnt <= last_data ? '0 : bit_cnt + BW'(1);
    end else if (stop_en) begin
      bit_cnt <= last_stop ? '0 : bit_cnt + BW'(1);
    end
  end

  // Deserialiser: MSB arrives first, so shift towards the MSB.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_reg <= '0;
    end else if (shift_en) begin
      shift_reg <= {shift_reg[DataBits-2:0], bit_val};
    end
  end

  // Sticky per-frame error state, cleared while idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par_err    <= 1'b0;
      frame_flag <= 1'b0;
    end else if (state == IDLE) begin
      par_err    <= 1'b0;
      frame_flag <= 1'b0;
    end else begin
      if (par_en)              par_err    <= bit_val ^ (^shift_reg);
      if (stop_en && !bit_val) frame_flag <= 1'b1;
    end
  end

  // Result strobe: word and status presented together for exactly one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out       <= '0;
      data_out_valid <= 1'b0;
      parity_error   <= 1'b0;
      frame_error    <= 1'b0;
    end else begin
      data_out_valid <= frame_done;
      parity_error   <= frame_done & par_err;
      frame_error    <= frame_done & (frame_flag | ~bit_val);
      if (frame_done) data_out <= shift_reg;
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frames into two receivers (no parity / even parity), 8 clk per bit.
// Strobes are recorded by a negedge monitor; expected values are hand-computed constants.
// Ends with a single TB_RESULT summary line.

module tb_uart_rx;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in0 = 1'b1;
  logic       in1 = 1'b1;

  logic [7:0] d0, d1;
  logic       v0, v1, pe0, pe1, fe0, fe1, b0, b1;

  int checks   = 0;
  int failures = 0;

  // Monitor state
  int         n0 = 0, n1 = 0, err0 = 0, leak = 0;
  logic [7:0] q0[$];
  logic [7:0] last_d1 = 8'h00;
  logic       last_pe0 = 1'b0, last_fe0 = 1'b0, last_pe1 = 1'b0, last_fe1 = 1'b0;
  longint     t_strobe0 = 0;
  longint     t_start = 0;
  int         base0, base1, base_err;

  always #5 clk = ~clk;

  uart_rx #(.ClockDivider(8), .DataBits(8), .StopBits(1), .ParityBits(0)) dut0 (
    .clk(clk), .rst(rst), .in_bit(in0), .data_out(d0), .data_out_valid(v0),
    .parity_error(pe0), .frame_error(fe0), .busy(b0)
  );

  uart_rx #(.ClockDivider(8), .DataBits(8), .StopBits(1), .ParityBits(1)) dut1 (
    .clk(clk), .rst(rst), .in_bit(in1), .data_out(d1), .data_out_valid(v1),
    .parity_error(pe1), .frame_error(fe1), .busy(b1)
  );

  // Record strobes and any error flag raised outside a strobe.
  always @(negedge clk) begin
    if (v0) begin
      n0        <= n0 + 1;
      q0.push_back(d0);
      last_pe0  <= pe0;
      last_fe0  <= fe0;
      err0      <= err0 + ((pe0 | fe0) ? 1 : 0);
      t_strobe0 <= $time;
    end
    if (v1) begin
      n1       <= n1 + 1;
      last_d1  <= d1;
      last_pe1 <= pe1;
      last_fe1 <= fe1;
    end
    if ((!v0 && (pe0 || fe0)) || (!v1 && (pe1 || fe1))) leak <= leak + 1;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input bit line, input logic b);
    if (line) in1 = b;
    else      in0 = b;
    repeat (8) @(negedge clk);
  endtask

  task automatic send_frame(input bit line, input logic [7:0] d, input logic par, input logic stp);
    drive(line, 1'b0);
    for (int i = 7; i >= 0; i--) drive(line, d[i]);
    if (line) drive(line, par);
    drive(line, stp);
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_val("rst_dout",  {24'h0, d0}, 32'h00);
    check_val("rst_vld",   {31'h0, v0}, 32'h0);
    check_val("rst_pe",    {31'h0, pe0}, 32'h0);
    check_val("rst_fe",    {31'h0, fe0}, 32'h0);
    check_val("rst_busy",  {31'h0, b0}, 32'h0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Plain frame 0xA5 with latency measurement
    base0 = n0;
    t_start = $time;
    send_frame(1'b0, 8'hA5, 1'b0, 1'b1);
    repeat (10) @(negedge clk);
    check_val("a5_count", n0 - base0, 1);
    check_val("a5_data",  {24'h0, q0[$]}, 32'hA5);
    check_val("a5_pe",    {31'h0, last_pe0}, 32'h0);
    check_val("a5_fe",    {31'h0, last_fe0}, 32'h0);
    check_val("a5_busy",  {31'h0, b0}, 32'h0);
    check_val("a5_latency", 32'(t_strobe0 - t_start), 32'd790);

    // Two-cycle glitch: false start, no strobe
    base0 = n0;
    in0 = 1'b0;
    repeat (2) @(negedge clk);
    in0 = 1'b1;
    @(negedge clk);
    check_val("glitch_busy_hi", {31'h0, b0}, 32'h1);
    repeat (20) @(negedge clk);
    check_val("glitch_count", n0 - base0, 0);
    check_val("glitch_dout",  {24'h0, d0}, 32'hA5);
    check_val("glitch_busy_lo", {31'h0, b0}, 32'h0);

    // Parity receiver: 0x3C has even weight, so parity bit 1 is wrong and 0 is right
    base1 = n1;
    send_frame(1'b1, 8'h3C, 1'b1, 1'b1);
    repeat (10) @(negedge clk);
    check_val("par1_count", n1 - base1, 1);
    check_val("par1_data",  {24'h0, last_d1}, 32'h3C);
    check_val("par1_pe",    {31'h0, last_pe1}, 32'h1);
    check_val("par1_fe",    {31'h0, last_fe1}, 32'h0);
    base1 = n1;
    send_frame(1'b1, 8'h3C, 1'b0, 1'b1);
    repeat (10) @(negedge clk);
    check_val("par0_count", n1 - base1, 1);
    check_val("par0_data",  {24'h0, last_d1}, 32'h3C);
    check_val("par0_pe",    {31'h0, last_pe1}, 32'h0);
    check_val("par0_busy",  {31'h0, b1}, 32'h0);

    // Low stop bit followed by a held-low line
    base0 = n0;
    send_frame(1'b0, 8'h5A, 1'b0, 1'b0);
    repeat (40) @(negedge clk);
    check_val("brk_count", n0 - base0, 1);
    check_val("brk_data",  {24'h0, q0[$]}, 32'h5A);
    check_val("brk_fe",    {31'h0, last_fe0}, 32'h1);
    check_val("brk_pe",    {31'h0, last_pe0}, 32'h0);
    check_val("brk_busy",  {31'h0, b0}, 32'h1);
    in0 = 1'b1;
    repeat (20) @(negedge clk);
    check_val("brk_release_busy", {31'h0, b0}, 32'h0);
    check_val("brk_release_count", n0 - base0, 1);
    base0 = n0;
    send_frame(1'b0, 8'h12, 1'b0, 1'b1);
    repeat (10) @(negedge clk);
    check_val("post_brk_count", n0 - base0, 1);
    check_val("post_brk_data",  {24'h0, q0[$]}, 32'h12);
    check_val("post_brk_fe",    {31'h0, last_fe0}, 32'h0);

    // Back-to-back frames with no idle gap
    q0.delete();
    base0 = n0;
    base_err = err0;
    send_frame(1'b0, 8'h00, 1'b0, 1'b1);
    send_frame(1'b0, 8'hFF, 1'b0, 1'b1);
    send_frame(1'b0, 8'h81, 1'b0, 1'b1);
    repeat (10) @(negedge clk);
    check_val("b2b_count", n0 - base0, 3);
    check_val("b2b_qsize", q0.size(), 3);
    check_val("b2b_d0", {24'h0, q0[0]}, 32'h00);
    check_val("b2b_d1", {24'h0, q0[1]}, 32'hFF);
    check_val("b2b_d2", {24'h0, q0[2]}, 32'h81);
    check_val("b2b_errs", err0 - base_err, 0);

    // Reset during the data bits of 0x55, then a clean 0x66
    base0 = n0;
    drive(1'b0, 1'b0);
    drive(1'b0, 1'b0);
    drive(1'b0, 1'b1);
    drive(1'b0, 1'b0);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_val("midrst_busy", {31'h0, b0}, 32'h0);
    check_val("midrst_dout", {24'h0, d0}, 32'h00);
    rst = 1'b0;
    in0 = 1'b1;
    repeat (30) @(negedge clk);
    check_val("midrst_nostrobe", n0 - base0, 0);
    send_frame(1'b0, 8'h66, 1'b0, 1'b1);
    repeat (10) @(negedge clk);
    check_val("post_rst_count", n0 - base0, 1);
    check_val("post_rst_data",  {24'h0, q0[$]}, 32'h66);
    check_val("post_rst_fe",    {31'h0, last_fe0}, 32'h0);

    check_val("flag_leak", leak, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
UART receiver; the receiving end of the serial link driven by the team's uart_tx. It oversamples the asynchronous line at ClockDivider clocks per bit and deserialises one frame at a time. Each received word is presented with a single-cycle valid strobe, plus parity and framing status. It sits between the board RX pin and the CPU's MMIO UART register block.

Parameters:
- ClockDivider, 8, clk cycles per bit period; must be ≥ 4.
- DataBits, 8, data bits per frame; legal range [5,9].
- StopBits, 1, stop bits per frame; 1 or 2.
- ParityBits, 0, 1 enables an even-parity bit (parity bit = XOR of data bits); 0 or 1.
- Illegal values raise $error at elaboration.

Ports:
- clk  input  1  clock.
- rst  input  1  reset; asynchronous, active-high.
- in_bit  input  1  serial line, asynchronous to clk; idle high.
- data_out  output  DataBits  last received word; held until the next valid strobe.
- data_out_valid  output  1  one-cycle strobe when a frame completes.
- parity_error  output  1  qualified by data_out_valid; received parity ≠ XOR(data).
- frame_error  output  1  qualified by data_out_valid; a stop bit was sampled low.
- busy  output  1  high in every state except IDLE.

Behaviour:
- in_bit passes through a 2-flop synchroniser, reset to 1. All logic uses the synchronised value (rx).
- Frame format on the line: start (0), data MSB first, optional parity, StopBits stop bits (1).
- Reset values:
  - state = IDLE.
  - data_out = 0.
  - data_out_valid, parity_error, frame_error, busy = 0.
  - Bit counter and clock-divider counter = 0.
- FSM states: IDLE, START, DATA, PARITY, STOP, BREAK.
  - IDLE: counter held at 0. When rx = 0, go to START.
  - START: counter counts up to ClockDivider/2 − 1 (mid-bit).
    - At mid-bit, rx = 1 is a false start: go to IDLE, no strobe.
    - At mid-bit, rx = 0: reset the counter and go to DATA.
  - DATA: sample rx each time the counter reaches ClockDivider − 1 (one full bit later, i.e. mid-bit) and shift it into the shift register.
    - After DataBits samples, go to PARITY if ParityBits = 1, otherwise to STOP.
  - PARITY: sample one bit at mid-bit and latch the comparison against XOR of the shift register. Then go to STOP.
  - STOP: sample StopBits bits at mid-bit. Any low sample sets a sticky frame flag.
    - On the last stop sample, pulse data_out_valid for exactly 1 cycle (the cycle after that sample edge). In that same cycle, load data_out from the shift register and drive parity_error and frame_error.
    - Next state: IDLE if no frame error, else BREAK.
  - BREAK: wait until rx = 1, then go to IDLE. No strobe is issued in BREAK, so a held-low line produces exactly one frame_error.
- Latency: data_out_valid asserts 1 cycle after the mid-point of the final stop bit, plus the 2-cycle synchroniser delay measured from the in_bit transitions.
- Back-to-back frames: returning to IDLE at the stop-bit mid-point leaves half a bit of margin, so a start bit immediately following the stop bit is detected. There is no dead time requirement.
- Counter widths:
  - Clock divider: $clog2(ClockDivider).
  - Bit counter: $clog2(DataBits + 1).
  - Counter wrap is explicit compare-to-max, never overflow.
- Error flags are 0 whenever data_out_valid is 0.
- Reset asserted mid-frame: abort immediately to reset values, with no strobe. After release, the receiver resynchronises on the next falling edge of rx.
- There is no backpressure. The consumer must capture data_out on the strobe; data_out holds its value until the next strobe.

Optional Feature:
- Macro: UART_RX_MAJORITY_EN.
- Defined: every bit is sampled at counter positions mid−1, mid and mid+1. The bit value is the 2-of-3 majority, and it is committed at mid+1. All state transitions and the strobe shift 1 cycle later accordingly. This applies to the start-bit check too, so a glitch shorter than 2 cycles cannot start a frame.
- Undefined: a single sample at mid-bit. Latency is as stated above.

Test Plan:
- ClockDivider=8, DataBits=8, send 0xA5 with 1 stop bit -> exactly one data_out_valid pulse with data_out=0xA5, parity_error=0, frame_error=0, busy low afterwards.
- 2-cycle low glitch on an idle line -> START aborts at mid-bit, no strobe, data_out stays at its previous value.
- ParityBits=1, send 0x3C with the parity bit forced to 1 -> data_out=0x3C, parity_error=1. Same frame with parity bit 0 -> parity_error=0.
- Stop bit driven low, then line held low for 40 cycles -> one strobe with frame_error=1, FSM stays in BREAK. The next frame 0x12, sent after the line returns high, is received cleanly.
- Frames 0x00, 0xFF, 0x81 sent back-to-back with no idle gap -> three strobes with matching data, no errors.
- Assert rst during DATA of frame 0x55, release, then send 0x66 -> no strobe for 0x55, one strobe with data_out=0x66.
